// File: rtl/div_share_ctrl_if.sv
// Bundle between the two requesting datapaths, the shared divider and the
// arbitration controller. The controller takes the slave view; whatever
// drives requests and models the divider takes the master view.
interface div_share_ctrl_if #(
  parameter int WIDTH = 9
);
  // requester side
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] b1;
  logic             ack0;
  logic             ack1;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             dz;
  logic             err;
  logic             busy;
  // divider side
  logic             div_start;
  logic [WIDTH-1:0] div_a;
  logic [WIDTH-1:0] div_b;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] div_r;
  logic             div_ready;

  modport slave (
    input  req0, req1, a0, a1, b0, b1, div_q, div_r, div_ready,
    output ack0, ack1, q, r, dz, err, busy, div_start, div_a, div_b
  );

  modport master (
    output req0, req1, a0, a1, b0, b1, div_q, div_r, div_ready,
    input  ack0, ack1, q, r, dz, err, busy, div_start, div_a, div_b
  );
endinterface

// File: rtl/div_share_ctrl.sv
// Shares one sequential divider between two requesters with round-robin
// arbitration, a divide-by-zero bypass and a timeout guard.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  IDLE      | waiting for a request; grants and latches operands
//  ISSUE     | div_start held high for START_LEN cycles
//  WAIT_BUSY | waiting for the divider to drop ready (max 2 cycles)
//  WAIT_DONE | waiting for ready to return, timeout armed
//  RESP      | one-cycle ack to the granted requester
module div_share_ctrl #(
  parameter int WIDTH     = 9,
  parameter int START_LEN = 1,
  parameter int TIMEOUT   = 64
) (
  input logic              clk,
  input logic              rst,
  div_share_ctrl_if.slave  bus
);

  localparam int SW = (START_LEN > 1) ? $clog2(START_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [SW-1:0]    st_cnt;
  logic [TW-1:0]    tmo_cnt;
  logic             wb_cnt;
  logic             gnt_id;
  logic             rr_ptr;
  logic [WIDTH-1:0] div_a_q;
  logic [WIDTH-1:0] div_b_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] r_q;
  logic             dz_q;
  logic             err_q;

  logic             any_req;
  logic             gnt_sel;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic             b_zero;
  logic             start_done;
  logic             tmo_hit;

  // Winner selection: a lone requester wins, a tie goes to rr_ptr.
  always_comb begin
    any_req    = bus.req0 | bus.req1;
    gnt_sel    = (bus.req0 & bus.req1) ? rr_ptr : bus.req1;
    a_sel      = gnt_sel ? bus.a1 : bus.a0;
    b_sel      = gnt_sel ? bus.b1 : bus.b0;
    b_zero     = (b_sel == '0);
    start_done = (st_cnt == SW'(START_LEN - 1));
    tmo_hit    = (tmo_cnt == TW'(TIMEOUT - 1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; a returning ready wins over a simultaneous timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = b_zero ? RESP : ISSUE;
      end
      ISSUE: begin
        if (start_done) state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tmo_hit)                      state_nxt = RESP;
        else if (!bus.div_ready || wb_cnt) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.div_ready || tmo_hit) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the current state only.
  always_comb begin
    bus.ack0      = (state == RESP) && !gnt_id;
    bus.ack1      = (state == RESP) &&  gnt_id;
    bus.busy      = (state != IDLE);
    bus.div_start = (state == ISSUE);
    bus.div_a     = div_a_q;
    bus.div_b     = div_b_q;
    bus.q         = q_q;
    bus.r         = r_q;
    bus.dz        = dz_q;
    bus.err       = err_q;
  end

  // Phase counters: start length, the 2-cycle busy window, and the timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_cnt  <= '0;
      wb_cnt  <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      st_cnt  <= (state == ISSUE) ? st_cnt + SW'(1) : '0;
      wb_cnt  <= (state == WAIT_BUSY);
      tmo_cnt <= (state == WAIT_BUSY || state == WAIT_DONE) ? tmo_cnt + TW'(1) : '0;
    end
  end

  // Grant bookkeeping and result registers; q/r/dz/err only change on the
  // edge that enters RESP, so they stay steady between acks.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_id  <= 1'b0;
      rr_ptr  <= 1'b0;
      div_a_q <= '0;
      div_b_q <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_id  <= gnt_sel;
            div_a_q <= a_sel;
            div_b_q <= b_sel;
            if (b_zero) begin
              q_q   <= '1;
              r_q   <= a_sel;
              dz_q  <= 1'b1;
              err_q <= 1'b0;
            end
          end
        end
        WAIT_BUSY, WAIT_DONE: begin
          if (state == WAIT_DONE && bus.div_ready) begin
            q_q   <= bus.div_q;
            r_q   <= bus.div_r;
            dz_q  <= 1'b0;
            err_q <= 1'b0;
          end else if (tmo_hit) begin
            q_q   <= '0;
            r_q   <= '0;
            dz_q  <= 1'b0;
            err_q <= 1'b1;
          end
        end
        RESP:    rr_ptr <= ~gnt_id;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed bench for div_share_ctrl with a behavioural divider that drops
// ready on start and returns the result DIV_LAT cycles later.
module tb_div_share_ctrl;
  localparam int W       = 9;
  localparam int DIV_LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hang = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  div_share_ctrl_if #(.WIDTH(W)) bus ();

  div_share_ctrl #(.WIDTH(W), .START_LEN(1), .TIMEOUT(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Divider model; while hang is set it never finishes.
  logic [W-1:0] ma, mb;
  int           mcnt;
  always @(posedge clk) begin
    if (rst) begin
      bus.div_ready <= 1'b1;
      bus.div_q     <= '0;
      bus.div_r     <= '0;
      mcnt          <= 0;
    end else if (bus.div_start) begin
      bus.div_ready <= 1'b0;
      mcnt          <= DIV_LAT;
      ma            <= bus.div_a;
      mb            <= bus.div_b;
    end else if (!bus.div_ready && !hang) begin
      if (mcnt == 1) begin
        bus.div_ready <= 1'b1;
        bus.div_q     <= ma / mb;
        bus.div_r     <= ma % mb;
      end
      mcnt <= mcnt - 1;
    end
  end

  // Event counters sampled mid-cycle.
  int   n_ack0 = 0, n_ack1 = 0, n_start = 0;
  logic both_ack = 1'b0;
  logic start_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.ack0) n_ack0 <= n_ack0 + 1;
    if (bus.ack1) n_ack1 <= n_ack1 + 1;
    if (bus.ack0 && bus.ack1) both_ack <= 1'b1;
    if (bus.div_start && !start_prev) n_start <= n_start + 1;
    start_prev <= bus.div_start;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input int maxc, output int cyc, output int id,
                          output logic [W-1:0] oq, output logic [W-1:0] orr,
                          output logic odz, output logic oerr);
    cyc = 0; id = -1; oq = 'x; orr = 'x; odz = 1'bx; oerr = 1'bx;
    while (cyc < maxc) begin
      step();
      cyc++;
      if (bus.ack0 || bus.ack1) begin
        id   = bus.ack1 ? 1 : 0;
        oq   = bus.q;
        orr  = bus.r;
        odz  = bus.dz;
        oerr = bus.err;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, id, s0, a0c, a1c;
    logic [W-1:0] oq, orr;
    logic odz, oerr;

    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;

    // Reset state
    do_reset();
    step();
    check("rst_busy",  bus.busy, 0);
    check("rst_start", bus.div_start, 0);
    check("rst_ack",   {bus.ack1, bus.ack0}, 0);
    check("rst_q",     bus.q, 0);
    check("rst_r",     bus.r, 0);
    check("rst_flags", {bus.err, bus.dz}, 0);

    // 1: single request 65/2
    s0 = n_start; a1c = n_ack1;
    bus.a0 = 9'd65; bus.b0 = 9'd2; bus.req0 = 1'b1;
    wait_ack(50, cyc, id, oq, orr, odz, oerr);
    bus.req0 = 1'b0;
    check("t1_id",  id, 0);
    check("t1_lat", cyc, 7);
    check("t1_q",   oq, 32);
    check("t1_r",   orr, 1);
    check("t1_dz",  odz, 0);
    check("t1_err", oerr, 0);
    step(); step();
    check("t1_nstart", n_start - s0, 1);
    check("t1_noack1", n_ack1 - a1c, 0);

    // 2: simultaneous requests after reset, both held -> 0,1,0,1
    do_reset();
    bus.a0 = 9'd129; bus.b0 = 9'd3; bus.a1 = 9'd100; bus.b1 = 9'd7;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ack(50, cyc, id, oq, orr, odz, oerr);
      if (k == 3) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
      check($sformatf("t2_id%0d", k), id, k % 2);
      check($sformatf("t2_q%0d", k),  oq, (k % 2) ? 14 : 43);
      check($sformatf("t2_r%0d", k),  orr, (k % 2) ? 2 : 0);
    end
    step();

    // 3: divide by zero bypass
    s0 = n_start;
    bus.a1 = 9'd7; bus.b1 = 9'd0; bus.req1 = 1'b1;
    wait_ack(50, cyc, id, oq, orr, odz, oerr);
    bus.req1 = 1'b0;
    check("t3_id",  id, 1);
    check("t3_lat", cyc <= 3, 1);
    check("t3_q",   oq, 511);
    check("t3_r",   orr, 7);
    check("t3_dz",  odz, 1);
    check("t3_err", oerr, 0);
    step(); step();
    check("t3_nostart", n_start - s0, 0);

    // 4: divider hangs -> timeout, then normal service
    hang = 1'b1;
    bus.a0 = 9'd50; bus.b0 = 9'd5; bus.req0 = 1'b1;
    wait_ack(200, cyc, id, oq, orr, odz, oerr);
    bus.req0 = 1'b0;
    check("t4_id",  id, 0);
    check("t4_lat", (cyc >= 64) && (cyc <= 70), 1);
    check("t4_err", oerr, 1);
    check("t4_q",   oq, 0);
    check("t4_r",   orr, 0);
    check("t4_dz",  odz, 0);
    hang = 1'b0;
    step();
    bus.a1 = 9'd200; bus.b1 = 9'd9; bus.req1 = 1'b1;
    wait_ack(50, cyc, id, oq, orr, odz, oerr);
    bus.req1 = 1'b0;
    check("t4b_id",  id, 1);
    check("t4b_q",   oq, 22);
    check("t4b_r",   orr, 2);
    check("t4b_err", oerr, 0);
    step();

    // 5: reset during WAIT_DONE
    bus.a0 = 9'd100; bus.b0 = 9'd3; bus.req0 = 1'b1;
    step(); step(); step();
    check("t5_busy_pre", bus.busy, 1);
    a0c = n_ack0; a1c = n_ack1;
    rst = 1'b1; bus.req0 = 1'b0;
    step();
    rst = 1'b0;
    check("t5_busy",  bus.busy, 0);
    check("t5_start", bus.div_start, 0);
    check("t5_ack",   {bus.ack1, bus.ack0}, 0);
    check("t5_q",     bus.q, 0);
    for (int k = 0; k < 10; k++) step();
    check("t5_noack", (n_ack0 - a0c) + (n_ack1 - a1c), 0);
    bus.a0 = 9'd255; bus.b0 = 9'd16; bus.req0 = 1'b1;
    wait_ack(50, cyc, id, oq, orr, odz, oerr);
    bus.req0 = 1'b0;
    check("t5b_id", id, 0);
    check("t5b_q",  oq, 15);
    check("t5b_r",  orr, 15);
    step();

    // 6: req dropped mid-transaction still acks, nothing stray afterwards
    bus.a0 = 9'd90; bus.b0 = 9'd7; bus.req0 = 1'b1;
    step(); step(); step();
    bus.req0 = 1'b0;
    wait_ack(50, cyc, id, oq, orr, odz, oerr);
    check("t6_id", id, 0);
    check("t6_q",  oq, 12);
    check("t6_r",  orr, 6);
    step();
    a0c = n_ack0; a1c = n_ack1;
    for (int k = 0; k < 10; k++) step();
    check("t6_nostray", (n_ack0 - a0c) + (n_ack1 - a1c), 0);
    check("both_ack_never", both_ack, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
